pc_fetch_reg: RTL

- Program-counter register stage. Closes the fetch loop around the PC+1 adder.
- Drives the current PC to the adder and the instruction memory; captures the adder's `pc_next` each cycle.
- Handles branch redirect, pipeline stall, halt, and start/enable.
- Sits between the `pc_plus_1` adder, the branch-resolution logic and the instruction memory address port.

---
 rtl/pc_fetch_reg_pkg.sv | 22 ++
 rtl/pc_fetch_reg_if.sv | 44 ++++
 rtl/pc_fetch_ctrl.sv | 54 +++++
 rtl/pc_fetch_reg.sv | 79 +++++++
 4 files changed

// File: rtl/pc_fetch_reg_pkg.sv
// Shared definitions for the PC fetch stage: state encodings, next-PC select codes
// and default widths/reset vector shared with pc_plus_1 and the branch logic.
package pc_fetch_reg_pkg;

    localparam int          PC_WIDTH_DEF = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_NEXT   = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_RESET  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_fetch_reg_if.sv
// Fetch-stage bus: control/redirect inputs plus PC, fetch and status outputs.
// Breakpoint signals exist only when PC_BKPT_EN is defined.
interface pc_fetch_reg_if
    import pc_fetch_reg_pkg::*;
#(
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter int CNT_WIDTH       = 32
);
    logic                       en;
    logic [PC_WIDTH-1:0]        pc_next;
    logic                       br_taken;
    logic [PC_WIDTH-1:0]        br_target;
    logic                       stall;
    logic                       halt_req;
    logic [PC_WIDTH-1:0]        pc;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic                       fetch_valid;
    logic [1:0]                 fsm_state;
    logic [CNT_WIDTH-1:0]       fetch_count;
`ifdef PC_BKPT_EN
    logic [PC_WIDTH-1:0]        bkpt_addr;
    logic                       bkpt_arm;
    logic                       bkpt_hit;

    modport master (
        output en, pc_next, br_taken, br_target, stall, halt_req, bkpt_addr, bkpt_arm,
        input  pc, imem_addr, fetch_valid, fsm_state, fetch_count, bkpt_hit
    );
    modport slave (
        input  en, pc_next, br_taken, br_target, stall, halt_req, bkpt_addr, bkpt_arm,
        output pc, imem_addr, fetch_valid, fsm_state, fetch_count, bkpt_hit
    );
`else
    modport master (
        output en, pc_next, br_taken, br_target, stall, halt_req,
        input  pc, imem_addr, fetch_valid, fsm_state, fetch_count
    );
    modport slave (
        input  en, pc_next, br_taken, br_target, stall, halt_req,
        output pc, imem_addr, fetch_valid, fsm_state, fetch_count
    );
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch FSM and next-PC select; the PC register itself lives in the top.
//   state    | meaning
//   IDLE     | not enabled, PC holds
//   RUN      | fetching one PC per cycle
//   STALL    | PC held, no fetch, waiting for stall release or redirect
//   HALT     | stopped; en=0 returns to IDLE and reloads the reset PC
module pc_fetch_ctrl
    import pc_fetch_reg_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         br_taken,
    input  logic         stall,
    input  logic         halt_any,
    output fetch_state_t state,
    output pc_sel_t      pc_sel
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (en) state <= ST_RUN;
                ST_RUN, ST_STALL: begin
                    if (!en)           state <= ST_IDLE;
                    else if (halt_any) state <= ST_HALT;
                    else if (br_taken) state <= ST_RUN;
                    else if (stall)    state <= ST_STALL;
                    else               state <= ST_RUN;
                end
                ST_HALT: if (!en) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A redirect overrides stall; halt (or breakpoint) drops the redirect.
    always_comb begin
        pc_sel = SEL_HOLD;
        case (state)
            ST_RUN, ST_STALL: begin
                if (en && !halt_any) begin
                    if (br_taken)    pc_sel = SEL_TARGET;
                    else if (!stall) pc_sel = SEL_NEXT;
                end
            end
            ST_HALT: if (!en) pc_sel = SEL_RESET;
            default: pc_sel = SEL_HOLD;
        endcase
    end

endmodule

// File: rtl/pc_fetch_reg.sv
// Program-counter register stage: PC register, saturating fetch counter and,
// with PC_BKPT_EN defined, a breakpoint comparator that halts after the matching fetch.
module pc_fetch_reg
    import pc_fetch_reg_pkg::*;
#(
    parameter int                  PC_WIDTH        = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(RESET_PC_DEF),
    parameter int                  IMEM_ADDR_WIDTH = 9,
    parameter int                  CNT_WIDTH       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_reg_if.slave  bus
);

    fetch_state_t          state;
    pc_sel_t               pc_sel;
    logic                  halt_any;
    logic                  fetch_valid;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    pc_fetch_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .br_taken (bus.br_taken),
        .stall    (bus.stall),
        .halt_any (halt_any),
        .state    (state),
        .pc_sel   (pc_sel)
    );

`ifdef PC_BKPT_EN
    logic bkpt_cond;
    logic bkpt_hit_q;

    // Match is taken in RUN, so the matching PC is still fetched this cycle.
    assign bkpt_cond = (state == ST_RUN) && bus.bkpt_arm && (pc_q == bus.bkpt_addr);
    assign halt_any  = bus.halt_req | bkpt_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          bkpt_hit_q <= 1'b0;
        else if (state == ST_HALT && !bus.en) bkpt_hit_q <= 1'b0;
        else if (bkpt_cond && bus.en)         bkpt_hit_q <= 1'b1;
    end

    assign bus.bkpt_hit = bkpt_hit_q;
`else
    assign halt_any = bus.halt_req;
`endif

    assign fetch_valid = (state == ST_RUN) && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            case (pc_sel)
                SEL_NEXT:   pc_q <= bus.pc_next;
                SEL_TARGET: pc_q <= bus.br_target;
                SEL_RESET:  pc_q <= RESET_PC;
                default:    pc_q <= pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cnt_q <= '0;
        else if (fetch_valid && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = pc_q[IMEM_ADDR_WIDTH-1:0];
    assign bus.fetch_valid = fetch_valid;
    assign bus.fsm_state   = state;
    assign bus.fetch_count = cnt_q;

endmodule
